// File: rtl/csa_accum_resolver.sv
// -----------------------------------------------------------------------------
// csa_accum_resolver
//
// Purpose:
//    Multi-operand accumulator that keeps its running total in carry-save
//    (redundant sum/carry) form, performing one 3:2 compression per accepted
//    operand. When the final operand of a stream arrives, the redundant pair
//    is resolved to binary by a sequential CHUNK-bit ripple adder (LSB chunk
//    first), and the binary total is presented on a valid/ready output.
//
// Parameters:
//    WIDTH  operand width in bits
//    GUARD  extra accumulator bits (ACC_W = WIDTH + GUARD)
//    CHUNK  result bits resolved per cycle; ACC_W must be a multiple of CHUNK
//
// Ports:
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset (release assumed synchronous)
//    in_valid   in_data / in_last are valid
//    in_ready   block accepts an operand this cycle (only while accumulating)
//    in_data    unsigned operand, zero-extended to ACC_W
//    in_last    marks the final operand of a stream (sampled on accept only)
//    out_valid  out_sum / out_ovf are valid
//    out_ready  downstream takes the result
//    out_sum    binary total modulo 2^ACC_W
//    out_ovf    true total was >= 2^ACC_W
// -----------------------------------------------------------------------------
module csa_accum_resolver #(
   parameter int WIDTH = 4,
   parameter int GUARD = 4,
   parameter int CHUNK = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH+GUARD-1:0] out_sum,
   output logic                   out_ovf
);

   localparam int ACC_W  = WIDTH + GUARD;
   localparam int NCHUNK = ACC_W / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

   // The resolver walks whole chunks only; a partial top chunk is not supported.
   generate
      if ((ACC_W % CHUNK) != 0) begin : g_bad_chunk
         $error("csa_accum_resolver: ACC_W (%0d) is not a multiple of CHUNK (%0d)",
                ACC_W, CHUNK);
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_ACCUM   = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_OUTPUT  = 2'd2
   } state_t;

   state_t             state_reg;
   state_t             state_next;

   logic [ACC_W-1:0]   s_reg;          // redundant sum vector
   logic [ACC_W-1:0]   c_reg;          // redundant carry vector (already shifted)
   logic               ovf_reg;        // sticky: some carry fell off the top
   logic               cy_reg;         // ripple carry between resolve chunks
   logic [IDX_W-1:0]   idx_reg;        // chunk being resolved
   logic [ACC_W-1:0]   sum_reg;        // binary result, filled chunk by chunk
   logic               out_valid_reg;

   logic               accept;
   logic               take;
   logic               chunk_last;

   // ------------------------------------------------------------------
   // 3:2 compression of (s, c, x)
   // ------------------------------------------------------------------
   logic [ACC_W-1:0]   x_ext;
   logic [ACC_W-1:0]   csa_sum;
   logic [ACC_W-1:0]   csa_maj;

   assign x_ext   = ACC_W'(in_data);
   assign csa_sum = s_reg ^ c_reg ^ x_ext;
   assign csa_maj = (s_reg & c_reg) | (s_reg & x_ext) | (c_reg & x_ext);

   // ------------------------------------------------------------------
   // Chunk slicing for the sequential resolver
   // ------------------------------------------------------------------
   logic [CHUNK-1:0]   s_chunk [NCHUNK];
   logic [CHUNK-1:0]   c_chunk [NCHUNK];

   generate
      for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
         assign s_chunk[gi] = s_reg[gi*CHUNK +: CHUNK];
         assign c_chunk[gi] = c_reg[gi*CHUNK +: CHUNK];
      end
   endgenerate

   logic               cy_in;
   logic [CHUNK:0]     chunk_add;

   // Chunk 0 never sees a stale carry, even if cy_reg was left non-zero.
   assign cy_in      = (idx_reg == '0) ? 1'b0 : cy_reg;
   assign chunk_add  = {1'b0, s_chunk[idx_reg]}
                     + {1'b0, c_chunk[idx_reg]}
                     + {{CHUNK{1'b0}}, cy_in};
   assign chunk_last = (idx_reg == IDX_LAST);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_ACCUM;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_ACCUM: begin
            if (accept && in_last) begin
               state_next = ST_RESOLVE;
            end
         end
         ST_RESOLVE: begin
            if (chunk_last) begin
               state_next = ST_OUTPUT;
            end
         end
         ST_OUTPUT: begin
            if (take) begin
               state_next = ST_ACCUM;
            end
         end
         default: state_next = ST_ACCUM;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      in_ready  = (state_reg == ST_ACCUM);
      accept    = in_valid & (state_reg == ST_ACCUM);
      // A handshake needs the registered valid; out_ready during the
      // cycle that enters OUTPUT is therefore ignored.
      take      = (state_reg == ST_OUTPUT) & out_valid_reg & out_ready;
      out_valid = out_valid_reg;
      out_sum   = sum_reg;
      out_ovf   = out_valid_reg & ovf_reg;
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_reg         <= '0;
         c_reg         <= '0;
         ovf_reg       <= 1'b0;
         cy_reg        <= 1'b0;
         idx_reg       <= '0;
         sum_reg       <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_ACCUM: begin
               if (accept) begin
                  s_reg   <= csa_sum;
                  c_reg   <= {csa_maj[ACC_W-2:0], 1'b0};
                  // The top majority bit has nowhere to go: remember it.
                  ovf_reg <= ovf_reg | csa_maj[ACC_W-1];
               end
            end
            ST_RESOLVE: begin
               sum_reg[idx_reg*CHUNK +: CHUNK] <= chunk_add[CHUNK-1:0];
               cy_reg                          <= chunk_add[CHUNK];
               if (chunk_last) begin
                  idx_reg <= '0;
                  ovf_reg <= ovf_reg | chunk_add[CHUNK];
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end
            ST_OUTPUT: begin
               // First OUTPUT cycle raises valid; the result and ovf are
               // already final, so they stay put until the handshake.
               if (!out_valid_reg) begin
                  out_valid_reg <= 1'b1;
               end else if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  s_reg         <= '0;
                  c_reg         <= '0;
                  ovf_reg       <= 1'b0;
                  cy_reg        <= 1'b0;
                  idx_reg       <= '0;
               end
            end
            default: begin
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule
